// File: rtl/dual_grant_sequencer_pkg.sv
// Shared constants, state encoding and index helpers for the dual-grant sequencer
// and the priority encoder it wraps.
package dpe_pkg;

    localparam int N = 12;
    localparam int IW = 4;
    localparam logic [IW-1:0] IDX_NONE = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Index k (1..N) selects request bit k-1; zero and out-of-range indices map to no bit.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [N-1:0] oh;
        oh = '0;
        for (int k = 1; k <= N; k++) begin
            if (idx == IW'(k)) oh[k-1] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/dual_grant_sequencer_if.sv
// Request/encoder/grant bundle. master = sequencer side, slave = environment side.
interface dual_grant_sequencer_if import dpe_pkg::*; #(parameter int CW = 16);

    logic [N-1:0]  req_in;
    logic [N-1:0]  req_pend;
    logic [IW-1:0] first;
    logic [IW-1:0] second;
    // Each grant channel: a transfer happens on a clock edge where valid and ready are
    // both high; valid and idx hold steady until then, and ready with valid low is ignored.
    logic          g0_valid;
    logic [IW-1:0] g0_idx;
    logic          g0_ready;
    logic          g1_valid;
    logic [IW-1:0] g1_idx;
    logic          g1_ready;
    logic          busy;
    logic [CW-1:0] grant_count;

    modport master (
        input  req_in, first, second, g0_ready, g1_ready,
        output req_pend, g0_valid, g0_idx, g1_valid, g1_idx, busy, grant_count
    );

    modport slave (
        output req_in, first, second, g0_ready, g1_ready,
        input  req_pend, g0_valid, g0_idx, g1_valid, g1_idx, busy, grant_count
    );

endinterface

// File: rtl/dual_grant_sequencer_grant_channel.sv
// One grant channel: loads an index, holds it until accepted, and reports which
// request bit the acceptance retires.
module grant_channel import dpe_pkg::*; (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    input  logic          ready,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic          fire,
    output logic [N-1:0]  clr
);

    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;

    assign fire  = valid_q & ready;
    assign clr   = fire ? idx_to_onehot(idx_q) : '0;
    assign valid = valid_q;
    assign idx   = idx_q;

    // Loads only occur while the channel is empty, so load and fire never overlap.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = load_idx;
        end else if (fire) begin
            valid_d = 1'b0;
            idx_d   = IDX_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= IDX_NONE;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/dual_grant_sequencer.sv
// Sticky request accumulator around a dual priority encoder, issuing the encoder's
// two picks as independent grants and retiring requests only on acceptance.
module dual_grant_sequencer import dpe_pkg::*; #(parameter int CW = 16) (
    input  logic                   clk,
    input  logic                   reset,
    dual_grant_sequencer_if.master bus,
    output state_e                 dbg_state
);

    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  inflight_q, inflight_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_sum;

    logic [N-1:0]  first_oh, second_oh;
    logic          load0, load1;
    logic          v0, v1, fire0, fire1;
    logic [IW-1:0] idx0, idx1;
    logic [N-1:0]  clr0, clr1;

    assign first_oh  = idx_to_onehot(bus.first);
    assign second_oh = idx_to_onehot(bus.second);
    assign load0     = (state_q == IDLE) && (first_oh != '0);
    assign load1     = (state_q == IDLE) && (second_oh != '0) && (bus.second != bus.first);

    grant_channel u_ch0 (
        .clk(clk), .reset(reset), .load(load0), .load_idx(bus.first), .ready(bus.g0_ready),
        .valid(v0), .idx(idx0), .fire(fire0), .clr(clr0)
    );

    grant_channel u_ch1 (
        .clk(clk), .reset(reset), .load(load1), .load_idx(bus.second), .ready(bus.g1_ready),
        .valid(v1), .idx(idx1), .fire(fire1), .clr(clr1)
    );

    // A request arriving on the same edge its grant is accepted survives: set beats clear.
    always_comb begin
        pend_d     = (pend_q & ~(clr0 | clr1)) | bus.req_in;
        inflight_d = inflight_q & ~(clr0 | clr1);
        if (load0) inflight_d = inflight_d | first_oh;
        if (load1) inflight_d = inflight_d | second_oh;

        cnt_sum = {1'b0, cnt_q} + (CW+1)'(fire0) + (CW+1)'(fire1);
        cnt_d   = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];

        state_d = state_q;
        case (state_q)
            IDLE:    if (load0 || load1) state_d = ISSUE;
            ISSUE:   if (!(v0 && !fire0) && !(v1 && !fire1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            inflight_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // Masking from registers only keeps the encoder outputs off the req_pend path.
    assign bus.req_pend    = pend_q & ~inflight_q;
    assign bus.g0_valid    = v0;
    assign bus.g0_idx      = idx0;
    assign bus.g1_valid    = v1;
    assign bus.g1_idx      = idx1;
    assign bus.busy        = (state_q == ISSUE);
    assign bus.grant_count = cnt_q;
    assign dbg_state       = state_q;

endmodule
